core_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It fetches an instruction over the instruction-memory handshake and holds it stable for the instruction decoder. It then steps the datapath through decode, execute, data-memory access and writeback, and owns the program counter. It sits between the memory interfaces and the decoder/ALU/register-file datapath, and produces every per-stage enable the datapath needs.

---
 rtl/core_sequencer.sv | 127 ++++++++++++
 tb/tb_core_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch handshake, instruction latch,
// per-stage datapath strobes, program counter and retired-instruction counter.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        instr_legal,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        rd_valid,
  input  logic [4:0]  rd,
  input  logic        redirect,
  input  logic [31:0] target_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        load_capture,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            redirect_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  // Next state and Moore-style strobes; rf_we/retire/load_capture also
  // qualify on decoder flags, which are stable from DECODE to WRITEBACK.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instret_d      = instret_q;
    imem_req       = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    load_capture   = 1'b0;
    rf_we          = 1'b0;
    retire         = 1'b0;
    halted         = 1'b0;
    redirect_fault = redirect && (target_pc[1:0] != 2'b00);

    case (state_q)
      S_FETCH: begin
        // Held in FETCH during reset; the request must not show until release.
        imem_req = !rst;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = instr_legal ? S_EXECUTE : S_HALT;
      end
      S_EXECUTE: begin
        state_d = (is_load || is_store) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          load_capture = is_load;
          state_d      = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (redirect_fault) begin
          state_d = S_HALT;
        end else begin
          rf_we     = rd_valid && (rd != 5'd0) && !is_store;
          retire    = 1'b1;
          instret_d = instret_q + XLEN'(1);
          pc_d      = redirect ? target_pc : pc_q + XLEN'(4);
          state_d   = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer with hand-computed expectations.
module tb_core_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_legal;
  logic        is_load;
  logic        is_store;
  logic        rd_valid;
  logic [4:0]  rd;
  logic        redirect;
  logic [31:0] target_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        load_capture;
  logic        rf_we;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        halted;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_instr;

  core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_legal  (instr_legal),
    .is_load      (is_load),
    .is_store     (is_store),
    .rd_valid     (rd_valid),
    .rd           (rd),
    .redirect     (redirect),
    .target_pc    (target_pc),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .load_capture (load_capture),
    .rf_we        (rf_we),
    .pc           (pc),
    .retire       (retire),
    .instret      (instret),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instret", instret, 32'h0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    tick();
    rst = 1'b0;
    exp_instr = 32'h0000_0013;
    #1;
    check("post_rst_imem_req", {31'd0, imem_req}, 32'd1);
  endtask

  // Runs one instruction from the start of its FETCH cycle until retire or
  // halt, acknowledging each request after the requested number of wait cycles.
  task automatic run_instr(input logic [31:0] word, input logic [31:0] exp_addr,
                           input int iwait, input int dwait, input logic legal,
                           input logic ld, input logic st, input logic rdv,
                           input logic [4:0] rdn, input logic redir, input logic [31:0] tgt,
                           output int cyc, output int dq, output int lc,
                           output int rw, output int rt, output logic hh);
    int   ic;
    int   dc;
    logic fetched;
    logic done;
    ic = 0; dc = 0; fetched = 1'b0; done = 1'b0;
    cyc = 0; dq = 0; lc = 0; rw = 0; rt = 0; hh = 1'b0;
    imem_rdata = word; instr_legal = legal; is_load = ld; is_store = st;
    rd_valid = rdv; rd = rdn; redirect = redir; target_pc = tgt;
    for (int c = 0; c < 40; c++) begin
      imem_ack = imem_req && (ic == iwait);
      dmem_ack = dmem_req && (dc == dwait);
      #1;
      cyc++;
      if (imem_req) begin
        check("imem_addr", imem_addr, exp_addr);
        check("instr_hold", instr, exp_instr);
        ic++;
      end else if (!fetched) begin
        fetched = 1'b1;
        exp_instr = word;
        check("instr_latch", instr, word);
      end
      if (dmem_req) begin
        check("dmem_we", {31'd0, dmem_we}, {31'd0, st});
        dq++;
        dc++;
      end
      lc += int'(load_capture);
      rw += int'(rf_we);
      rt += int'(retire);
      if (retire || halted) begin
        hh = halted;
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    tick();
  endtask

  initial begin
    int   cyc, dq, lc, rw, rt;
    logic hh;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_legal = 1'b0;
    is_load = 1'b0; is_store = 1'b0; rd_valid = 1'b0; rd = '0;
    redirect = 1'b0; target_pc = '0; dmem_ack = 1'b0;
    exp_instr = 32'h0000_0013;
    #2;
    apply_reset();

    // addi x1,x0,5 with immediate ack: 4 cycles, rf_we/retire in cycle 4
    run_instr(32'h0050_0093, 32'h0, 0, 0, 1, 0, 0, 1, 5'd1, 0, 32'h0, cyc, dq, lc, rw, rt, hh);
    check("alu_cycles", 32'(cyc), 32'd4);
    check("alu_rf_we", 32'(rw), 32'd1);
    check("alu_retire", 32'(rt), 32'd1);
    check("alu_pc", pc, 32'h4);
    check("alu_instret", instret, 32'd1);

    // fetch held off for 3 cycles: CPI 7, address and instr stable meanwhile
    run_instr(32'h0010_0113, 32'h4, 3, 0, 1, 0, 0, 1, 5'd2, 0, 32'h0, cyc, dq, lc, rw, rt, hh);
    check("fwait_cycles", 32'(cyc), 32'd7);
    check("fwait_pc", pc, 32'h8);
    check("fwait_instret", instret, 32'd2);

    // lw x3,4(x2) with dmem_ack delayed 2 cycles
    run_instr(32'h0041_2183, 32'h8, 0, 2, 1, 1, 0, 1, 5'd3, 0, 32'h0, cyc, dq, lc, rw, rt, hh);
    check("ld_cycles", 32'(cyc), 32'd7);
    check("ld_dmem_req_cycles", 32'(dq), 32'd3);
    check("ld_capture", 32'(lc), 32'd1);
    check("ld_rf_we", 32'(rw), 32'd1);
    check("ld_pc", pc, 32'hC);

    // sw x3,8(x0): rd_valid raised on purpose, store must still not write
    run_instr(32'h0030_2423, 32'hC, 0, 2, 1, 0, 1, 1, 5'd8, 0, 32'h0, cyc, dq, lc, rw, rt, hh);
    check("st_cycles", 32'(cyc), 32'd7);
    check("st_dmem_req_cycles", 32'(dq), 32'd3);
    check("st_capture", 32'(lc), 32'd0);
    check("st_rf_we", 32'(rw), 32'd0);
    check("st_retire", 32'(rt), 32'd1);
    check("st_instret", instret, 32'd4);

    // jal x0 to 0x100: redirect taken, rd=x0 suppresses rf_we but retires
    run_instr(32'h0F00_006F, 32'h10, 0, 0, 1, 0, 0, 1, 5'd0, 1, 32'h100, cyc, dq, lc, rw, rt, hh);
    check("jal_cycles", 32'(cyc), 32'd4);
    check("jal_rf_we", 32'(rw), 32'd0);
    check("jal_retire", 32'(rt), 32'd1);
    check("jal_pc", pc, 32'h100);
    check("jal_imem_addr", imem_addr, 32'h100);
    check("jal_instret", instret, 32'd5);

    // misaligned redirect target: halt, no retire, pc and instret frozen
    run_instr(32'h0000_02E7, 32'h100, 0, 0, 1, 0, 0, 1, 5'd5, 1, 32'h102, cyc, dq, lc, rw, rt, hh);
    check("fault_cycles", 32'(cyc), 32'd5);
    check("fault_halted", {31'd0, hh}, 32'd1);
    check("fault_retire", 32'(rt), 32'd0);
    check("fault_rf_we", 32'(rw), 32'd0);
    check("fault_pc", pc, 32'h100);
    check("fault_instret", instret, 32'd5);
    redirect = 1'b0;
    imem_ack = 1'b1;
    tick(); tick(); tick();
    check("halt_no_imem_req", {31'd0, imem_req}, 32'd0);
    check("halt_sticky", {31'd0, halted}, 32'd1);
    imem_ack = 1'b0;

    // illegal instruction halts straight after DECODE
    apply_reset();
    run_instr(32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 32'h0, cyc, dq, lc, rw, rt, hh);
    check("ill_cycles", 32'(cyc), 32'd3);
    check("ill_halted", {31'd0, hh}, 32'd1);
    check("ill_retire", 32'(rt), 32'd0);
    check("ill_instret", instret, 32'd0);

    // asynchronous reset in the middle of a data access
    apply_reset();
    run_instr(32'h0050_0093, 32'h0, 0, 0, 1, 0, 0, 1, 5'd1, 0, 32'h0, cyc, dq, lc, rw, rt, hh);
    check("pre_mem_pc", pc, 32'h4);
    imem_rdata = 32'h0041_2183; is_load = 1'b1; rd = 5'd3; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    check("mid_mem_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_drops_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_async_pc", pc, 32'h0);
    check("rst_async_instret", instret, 32'h0);
    check("rst_async_instr", instr, 32'h0000_0013);
    tick();
    rst = 1'b0;
    exp_instr = 32'h0000_0013;
    dmem_ack = 1'b1;
    #1;
    check("late_ack_imem_req", {31'd0, imem_req}, 32'd1);
    check("late_ack_dmem_req", {31'd0, dmem_req}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    check("late_ack_instr", instr, 32'h0000_0013);
    run_instr(32'h0050_0093, 32'h0, 0, 0, 1, 0, 0, 1, 5'd1, 0, 32'h0, cyc, dq, lc, rw, rt, hh);
    check("post_rst_cycles", 32'(cyc), 32'd4);
    check("post_rst_pc", pc, 32'h4);

    // retired-instruction counter wraps to zero
    imem_ack = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    tick();
    release dut.instret_q;
    #1;
    check("wrap_preload", instret, 32'hFFFF_FFFF);
    run_instr(32'h0050_0093, 32'h4, 0, 0, 1, 0, 0, 1, 5'd1, 0, 32'h0, cyc, dq, lc, rw, rt, hh);
    check("wrap_retire", 32'(rt), 32'd1);
    check("wrap_instret", instret, 32'h0);
    check("wrap_pc", pc, 32'h8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
